// File: rtl/arith_decoder_core.sv
// Multi-symbol / boolean arithmetic decoder core: byte refill, ICDF search, renormalization.
// Optional statistics counters are built when DEC_STATS_EN is defined.
module arith_decoder_core #(
    parameter int unsigned RANGE_WIDTH  = 16,
    parameter int unsigned SYMBOL_WIDTH = 4,
    parameter int unsigned D_SIZE       = 5,
    parameter int unsigned WINDOW_WIDTH = 40
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              in_byte,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_eos,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_bool,
    input  logic [SYMBOL_WIDTH:0]   req_nsyms,
    output logic [SYMBOL_WIDTH-1:0] cdf_idx,
    input  logic [15:0]             cdf_val,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SYMBOL_WIDTH-1:0] out_symbol,
    output logic [RANGE_WIDTH-1:0]  out_range,
    output logic [D_SIZE-1:0]       out_d,
    output logic [31:0]             stat_symbols,
    output logic [31:0]             stat_bytes
);

    localparam int unsigned VB_W  = $clog2(WINDOW_WIDTH + 1);
    localparam int unsigned VW    = RANGE_WIDTH + 1;
    localparam int unsigned SHIFT = WINDOW_WIDTH - RANGE_WIDTH;
    localparam int unsigned PW    = 18;
    localparam logic [VB_W-1:0] FILL_LIM = VB_W'(WINDOW_WIDTH - 8);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_SEARCH,
        S_NORM,
        S_REFILL,
        S_OUT
    } state_t;

    state_t                    state_q, state_d;
    logic [RANGE_WIDTH-1:0]    rng_q, rng_d;
    logic [WINDOW_WIDTH-1:0]   dif_q, dif_d;
    logic [VB_W-1:0]           vbits_q, vbits_d;
    logic [SYMBOL_WIDTH-1:0]   k_q, k_d;
    logic [VW-1:0]             v_q, v_d;
    logic                      bool_q, bool_d;
    logic [SYMBOL_WIDTH:0]     nsyms_q, nsyms_d;
    logic [SYMBOL_WIDTH-1:0]   sym_q, sym_d;
    logic                      want_q, want_d;
    logic [SYMBOL_WIDTH-1:0]   out_symbol_q, out_symbol_d;
    logic [RANGE_WIDTH-1:0]    out_range_q, out_range_d;
    logic [D_SIZE-1:0]         out_d_q, out_d_d;

    // Count of leading zeros across the range register.
    function automatic logic [D_SIZE-1:0] lzc(input logic [RANGE_WIDTH-1:0] x);
        logic [D_SIZE-1:0] n;
        n = D_SIZE'(RANGE_WIDTH);
        for (int i = 0; i < RANGE_WIDTH; i++) begin
            if (x[i]) n = D_SIZE'(RANGE_WIDTH - 1 - i);
        end
        return n;
    endfunction

    logic [RANGE_WIDTH-1:0]  c_win;
    logic [PW-1:0]           prod;
    logic [VW-1:0]           v_base;
    logic [VW-1:0]           v_bool;
    logic [VW-1:0]           v_cdf;
    logic [SYMBOL_WIDTH:0]   rem;
    logic                    last_k;
    logic                    bool_hit;
    logic                    byte_go;
    logic [7:0]              byte_val;
    logic [VB_W-1:0]         vb_add;
    logic [D_SIZE-1:0]       norm_d;

    // Shared ICDF multiply: (rng >> 8) * (icdf >> 6) >> 1.
    always_comb begin
        c_win    = dif_q[WINDOW_WIDTH-1 -: RANGE_WIDTH];
        prod     = PW'(rng_q[RANGE_WIDTH-1 -: 8]) * PW'(cdf_val[15:6]);
        v_base   = prod[PW-1:1];
        v_bool   = v_base + VW'(4);
        rem      = nsyms_q - (SYMBOL_WIDTH+1)'(1) - (SYMBOL_WIDTH+1)'(k_q);
        last_k   = ((SYMBOL_WIDTH+1)'(k_q) == (nsyms_q - (SYMBOL_WIDTH+1)'(1)));
        v_cdf    = last_k ? '0 : (v_base + VW'({rem, 2'b00}));
        bool_hit = ({1'b0, dif_q} >= {v_bool, {SHIFT{1'b0}}});
        byte_go  = want_q && (in_eos || in_valid);
        byte_val = in_eos ? 8'h00 : in_byte;
        vb_add   = vbits_q + VB_W'(8);
        norm_d   = lzc(rng_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_INIT;
            rng_q        <= RANGE_WIDTH'(1) << (RANGE_WIDTH - 1);
            dif_q        <= '1;
            vbits_q      <= '0;
            k_q          <= '0;
            v_q          <= '0;
            bool_q       <= 1'b0;
            nsyms_q      <= '0;
            sym_q        <= '0;
            want_q       <= 1'b0;
            out_symbol_q <= '0;
            out_range_q  <= '0;
            out_d_q      <= '0;
        end else begin
            state_q      <= state_d;
            rng_q        <= rng_d;
            dif_q        <= dif_d;
            vbits_q      <= vbits_d;
            k_q          <= k_d;
            v_q          <= v_d;
            bool_q       <= bool_d;
            nsyms_q      <= nsyms_d;
            sym_q        <= sym_d;
            want_q       <= want_d;
            out_symbol_q <= out_symbol_d;
            out_range_q  <= out_range_d;
            out_d_q      <= out_d_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rng_d        = rng_q;
        dif_d        = dif_q;
        vbits_d      = vbits_q;
        k_d          = k_q;
        v_d          = v_q;
        bool_d       = bool_q;
        nsyms_d      = nsyms_q;
        sym_d        = sym_q;
        out_symbol_d = out_symbol_q;
        out_range_d  = out_range_q;
        out_d_d      = out_d_q;

        unique case (state_q)
            S_INIT, S_REFILL: begin
                // Bytes land just below the valid bits; padding is a zero byte.
                if (byte_go) begin
                    dif_d   = dif_q ^ (WINDOW_WIDTH'(byte_val) << (FILL_LIM - vbits_q));
                    vbits_d = vb_add;
                    if (vb_add > FILL_LIM) begin
                        state_d = (state_q == S_INIT) ? S_IDLE : S_OUT;
                    end
                end
            end
            S_IDLE: begin
                if (req_valid) begin
                    bool_d  = req_bool;
                    nsyms_d = req_nsyms;
                    k_d     = '0;
                    v_d     = VW'(rng_q);
                    state_d = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (bool_q) begin
                    if (bool_hit) begin
                        sym_d = '0;
                        rng_d = rng_q - RANGE_WIDTH'(v_bool);
                        dif_d = dif_q - WINDOW_WIDTH'({v_bool, {SHIFT{1'b0}}});
                    end else begin
                        sym_d = SYMBOL_WIDTH'(1);
                        rng_d = RANGE_WIDTH'(v_bool);
                    end
                    state_d = S_NORM;
                end else if (!last_k && ({1'b0, c_win} < v_cdf)) begin
                    v_d = v_cdf;
                    k_d = k_q + SYMBOL_WIDTH'(1);
                end else begin
                    // v_q holds the previous boundary (u) of the selected interval.
                    sym_d   = k_q;
                    rng_d   = RANGE_WIDTH'(v_q - v_cdf);
                    dif_d   = dif_q - WINDOW_WIDTH'({v_cdf, {SHIFT{1'b0}}});
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                rng_d        = rng_q << norm_d;
                dif_d        = ((dif_q + WINDOW_WIDTH'(1)) << norm_d) - WINDOW_WIDTH'(1);
                vbits_d      = vbits_q - VB_W'(norm_d);
                out_symbol_d = sym_q;
                out_range_d  = rng_q << norm_d;
                out_d_d      = norm_d;
                state_d      = (vbits_d <= FILL_LIM) ? S_REFILL : S_OUT;
            end
            S_OUT: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Byte demand is registered so it reads 0 throughout reset.
    always_comb begin
        want_d = ((state_d == S_INIT) || (state_d == S_REFILL)) && (vbits_d <= FILL_LIM);
    end

    assign in_ready   = want_q && !in_eos;
    assign req_ready  = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_OUT);
    assign cdf_idx    = k_q;
    assign out_symbol = out_symbol_q;
    assign out_range  = out_range_q;
    assign out_d      = out_d_q;

`ifdef DEC_STATS_EN
    logic [31:0] stat_symbols_q;
    logic [31:0] stat_bytes_q;

    // Delivered symbols and real (non-padding) bytes; both wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_symbols_q <= '0;
            stat_bytes_q   <= '0;
        end else begin
            if (out_valid && out_ready) stat_symbols_q <= stat_symbols_q + 32'd1;
            if (in_valid && in_ready)   stat_bytes_q   <= stat_bytes_q + 32'd1;
        end
    end

    assign stat_symbols = stat_symbols_q;
    assign stat_bytes   = stat_bytes_q;
`else
    assign stat_symbols = '0;
    assign stat_bytes   = '0;
`endif

endmodule
